// File: rtl/irq_request_ctrl_pkg.sv
// Shared defaults and types for the interrupt request controller.
// Priority order: a higher line index always wins over a lower one.
package irq_request_ctrl_pkg;

  localparam int DEFAULT_NUM_IRQ         = 3;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_WIDTH       = 3;
  localparam int DEFAULT_ID_WIDTH        = 2;

  // Observable state of the request output towards the cpu.
  typedef enum logic {
    REQ_IDLE   = 1'b0,
    REQ_ACTIVE = 1'b1
  } req_state_t;

endpackage

// File: rtl/irq_debounce.sv
// One button line: two-flop synchroniser, debounce counter and accepted level.
// rise is high in the cycle whose closing edge accepts a 0->1 change.
module irq_debounce
  import irq_request_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1;
  logic                 s2;
  logic                 deb;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept;

  assign accept = (s2 != deb) && (cnt == CNT_LAST);
  assign rise   = accept && s2;

  // NOTE: non-blocking assignments let s1->s2 shift correctly within one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (accept) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_request_ctrl.sv
// Initiator side of the cpu interrupt handshake: pending latch, nest stack,
// priority selection and the registered irq_req/irq_id pair.
module irq_request_ctrl
  import irq_request_ctrl_pkg::*;
#(
  parameter int NUM_IRQ         = DEFAULT_NUM_IRQ,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH,
  parameter int ID_WIDTH        = DEFAULT_ID_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  btn,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                irq_ack,
  input  logic                irq_eret,
  output logic                irq_req,
  output logic [ID_WIDTH-1:0] irq_id,
  output logic [NUM_IRQ-1:0]  irw,
  output logic [NUM_IRQ-1:0]  in_service
);

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  ack_onehot;
  logic [NUM_IRQ-1:0]  svc_after_eret;
  logic [NUM_IRQ-1:0]  svc_nxt;
  logic [NUM_IRQ-1:0]  pend_after_ack;
  logic [NUM_IRQ-1:0]  pend_nxt;
  logic [NUM_IRQ-1:0]  eligible;
  logic [ID_WIDTH-1:0] id_nxt;
  logic                eret_found;
  logic                svc_seen;
  req_state_t          state;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_debounce (
      .clk (clk),
      .rst (rst),
      .btn (btn[g]),
      .rise(rise[g])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ack_onehot = '0;
    if (irq_ack && irq_req) ack_onehot[irq_id] = 1'b1;

    // eret retires the innermost handler before any same-cycle ack lands.
    svc_after_eret = in_service;
    eret_found     = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_eret && !eret_found && in_service[i]) begin
        svc_after_eret[i] = 1'b0;
        eret_found        = 1'b1;
      end
    end
    svc_nxt = svc_after_eret | ack_onehot;

    pend_after_ack = pending & ~ack_onehot;
    pend_nxt       = pend_after_ack | rise;

    // Eligibility sees this cycle's ack/eret but not this cycle's new edges,
    // so a request drops right after ack yet a new press still costs one edge.
    eligible = '0;
    svc_seen = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      svc_seen    = svc_seen | svc_nxt[i];
      eligible[i] = pend_after_ack[i] & ~irq_mask[i] & ~svc_seen;
    end

    id_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) id_nxt = ID_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= REQ_IDLE;
      irq_id     <= '0;
      pending    <= '0;
      in_service <= '0;
    end else begin
      pending    <= pend_nxt;
      in_service <= svc_nxt;
      irq_id     <= id_nxt;
      state      <= (|eligible) ? REQ_ACTIVE : REQ_IDLE;
    end
  end

  assign irq_req = (state == REQ_ACTIVE);
  assign irw     = pending;

endmodule
